// File: rtl/multicycle_control_pkg.sv
// Package: multicycle_control_pkg
// Shared encodings for the multicycle RV32I control path: ALU operation
// codes, opcode constants, datapath mux encodings, the ALU-operation class
// handed to the ALU decoder, and the opcode legality check.
package multicycle_control_pkg;

  // ALU operation codes driven on alu_control
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  // RV32I major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Datapath mux encodings
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC  = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_MEMDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES   = 2'b10;

  // Class of ALU work requested by the FSM; refined by funct3/funct7b5
  typedef enum logic [2:0] {
    ALUOP_ADD,
    ALUOP_BRANCH,
    ALUOP_RTYPE,
    ALUOP_ITYPE,
    ALUOP_LUI
  } alu_op_t;

  // True for opcodes outside the supported set and for branch funct3 010/011
  function automatic logic is_illegal(input logic [6:0] opcode,
                                      input logic [2:0] funct3);
    logic legal_op;
    legal_op = (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
               (opcode == OP_RTYPE)  || (opcode == OP_ITYPE) ||
               (opcode == OP_BRANCH) || (opcode == OP_JAL)   ||
               (opcode == OP_JALR)   || (opcode == OP_LUI)   ||
               (opcode == OP_AUIPC);
    return !legal_op || ((opcode == OP_BRANCH) && (funct3[2:1] == 2'b01));
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Module: multicycle_control_alu_decoder
// Combinational mapping {alu_op class, funct3, funct7b5} -> alu_control.
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_alu_control
);

  // Select the ALU operation for the requested class
  always_comb begin
    // NOTE: default first so every path assigns the output; no latch is inferred.
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_BRANCH: begin
        case (i_funct3[2:1])
          2'b00:   o_alu_control = ALU_SUB;   // beq / bne
          2'b10:   o_alu_control = ALU_SLT;   // blt / bge
          2'b11:   o_alu_control = ALU_SLTU;  // bltu / bgeu
          default: o_alu_control = ALU_ADD;   // unused: rejected in decode
        endcase
      end
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (i_funct3)
          // Immediate forms have no SUB; bit 30 is part of the immediate there.
          3'b000:  o_alu_control = (i_alu_op == ALUOP_RTYPE && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_control = ALU_SLL;
          3'b010:  o_alu_control = ALU_SLT;
          3'b011:  o_alu_control = ALU_SLTU;
          3'b100:  o_alu_control = ALU_XOR;
          3'b101:  o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_control = ALU_OR;
          default: o_alu_control = ALU_AND;
        endcase
      end
      ALUOP_LUI: o_alu_control = ALU_LUI;
      default:   o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Module: multicycle_control
// Multicycle RV32I control FSM driving datapath selects, write enables and
// alu_control; memory is sequenced through a mem_req/mem_ready handshake.
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN (illegal instructions
// park the FSM in TRAP and raise illegal_instr until reset).
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [3:0] alu_control
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK,
    S_LUI, S_TRAP
  } state_t;

  state_t  r_state;
  state_t  w_next_state;
  alu_op_t w_alu_op;
  logic    w_taken;
  logic    w_illegal;

  assign w_illegal = is_illegal(opcode, funct3);
  // Odd pairs (bne, blt, bltu) branch on a nonzero ALU result.
  assign w_taken   = (funct3[2] ^ funct3[0]) ? !zero : zero;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_illegal) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          w_next_state = S_TRAP;
`else
          w_next_state = S_FETCH;
`endif
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
            OP_RTYPE:          w_next_state = S_EXECR;
            OP_ITYPE:          w_next_state = S_EXECI;
            OP_BRANCH:         w_next_state = S_BRANCH;
            OP_JAL:            w_next_state = S_JAL;
            OP_JALR:           w_next_state = S_JALR;
            OP_LUI:            w_next_state = S_LUI;
            OP_AUIPC:          w_next_state = S_ALUWB;
            default:           w_next_state = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   w_next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
      S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH, S_LINK: w_next_state = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI:     w_next_state = S_ALUWB;
      S_JALR:     w_next_state = S_LINK;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Moore outputs, plus fetch handshake and branch decision; all quiet in reset
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    w_alu_op   = ALUOP_ADD;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALURES;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
        end
        S_MEMADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_MEMDATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = SRC_A_RS1;
          w_alu_op  = ALUOP_RTYPE;
        end
        S_EXECI: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          w_alu_op  = ALUOP_ITYPE;
        end
        S_ALUWB:  reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = SRC_A_RS1;
          pc_write  = w_taken;
          w_alu_op  = ALUOP_BRANCH;
        end
        S_JAL: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_FOUR;
          pc_write  = 1'b1;
        end
        S_JALR: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          result_src = RES_ALURES;
          pc_write   = 1'b1;
        end
        S_LINK: begin
          alu_src_a  = SRC_A_OLDPC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALURES;
          reg_write  = 1'b1;
        end
        S_LUI: begin
          alu_src_b = SRC_B_IMM;
          w_alu_op  = ALUOP_LUI;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign illegal_instr = !reset && (r_state == S_TRAP);
`endif

  multicycle_control_alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .o_alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench: tb_multicycle_control
// Directed instruction sequences with hand-computed control vectors,
// compared with immediate assertions at the falling clock edge.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_control;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .alu_control (alu_control)
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    ,
    .illegal_instr (illegal_instr)
`endif
  );

  logic [15:0] obs;
  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_control};

  // Expected control vector in the same field order as obs
  function automatic logic [15:0] ev(input logic mr, input logic mw, input logic as_,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] rs, input logic [3:0] alu);
    return {mr, mw, as_, irw, pcw, rw, a, b, rs, alu};
  endfunction

  function automatic logic [15:0] e_fetch(input logic rdy);
    return ev(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, 2'b10, ALU_ADD);
  endfunction

  function automatic logic [15:0] e_branch(input logic t, input logic [3:0] op);
    return ev(0, 0, 0, 0, t, 0, 2'b10, 2'b00, 2'b00, op);
  endfunction

  localparam logic [15:0] E_IDLE     = 16'h0000;
  localparam logic [15:0] E_DECODE   = {6'b000000, 2'b01, 2'b01, 2'b00, 4'd0};
  localparam logic [15:0] E_MEMADR   = {6'b000000, 2'b10, 2'b01, 2'b00, 4'd0};
  localparam logic [15:0] E_MEMREAD  = {6'b101000, 2'b00, 2'b00, 2'b00, 4'd0};
  localparam logic [15:0] E_MEMWB    = {6'b000001, 2'b00, 2'b00, 2'b01, 4'd0};
  localparam logic [15:0] E_MEMWRITE = {6'b111000, 2'b00, 2'b00, 2'b00, 4'd0};
  localparam logic [15:0] E_ALUWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 4'd0};
  localparam logic [15:0] E_JAL      = {6'b000010, 2'b01, 2'b10, 2'b00, 4'd0};
  localparam logic [15:0] E_JALR     = {6'b000010, 2'b10, 2'b01, 2'b10, 4'd0};
  localparam logic [15:0] E_LINK     = {6'b000001, 2'b01, 2'b10, 2'b10, 4'd0};

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge
  task automatic step(input string tag, input logic [15:0] e);
    @(negedge clk);
    check(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  task automatic load_instr(input logic [6:0] op, input logic [2:0] f3, input logic b5);
    opcode   = op;
    funct3   = f3;
    funct7b5 = b5;
  endtask

  task automatic fetch_decode(input string tag);
    step({tag, "_fetch"}, e_fetch(1'b1));
    step({tag, "_decode"}, E_DECODE);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    load_instr(OP_RTYPE, 3'b000, 1'b0);
    @(posedge clk); #1;
    step("reset_idle", E_IDLE);
    mem_ready = 1'b1;
    step("reset_ready_ignored", E_IDLE);
    reset = 1'b0;

    // add: four cycles, FETCH -> DECODE -> EXECR -> ALUWB
    fetch_decode("add");
    step("add_execr", ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, ALU_ADD));
    step("add_aluwb", E_ALUWB);

    // fetch stall while memory not ready, then sub
    mem_ready = 1'b0;
    load_instr(OP_RTYPE, 3'b000, 1'b1);
    step("fetch_stall", e_fetch(1'b0));
    mem_ready = 1'b1;
    fetch_decode("sub");
    step("sub_execr", ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, ALU_SUB));
    step("sub_aluwb", E_ALUWB);

    // addi with bit 30 set still adds
    load_instr(OP_ITYPE, 3'b000, 1'b1);
    fetch_decode("addi");
    step("addi_execi", ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ALU_ADD));
    step("addi_aluwb", E_ALUWB);

    load_instr(OP_ITYPE, 3'b101, 1'b1);
    fetch_decode("srai");
    step("srai_execi", ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ALU_SRA));
    step("srai_aluwb", E_ALUWB);

    load_instr(OP_ITYPE, 3'b101, 1'b0);
    fetch_decode("srli");
    step("srli_execi", ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ALU_SRL));
    step("srli_aluwb", E_ALUWB);

    // lw with three wait cycles in MEMREAD, single write-back pulse
    load_instr(OP_LOAD, 3'b010, 1'b0);
    fetch_decode("lw");
    step("lw_memadr", E_MEMADR);
    mem_ready = 1'b0;
    step("lw_wait0", E_MEMREAD);
    step("lw_wait1", E_MEMREAD);
    step("lw_wait2", E_MEMREAD);
    mem_ready = 1'b1;
    step("lw_done", E_MEMREAD);
    step("lw_memwb", E_MEMWB);

    // branches
    load_instr(OP_BRANCH, 3'b000, 1'b0);
    fetch_decode("beq_t");
    zero = 1'b1;
    step("beq_taken", e_branch(1'b1, ALU_SUB));
    fetch_decode("beq_nt");
    zero = 1'b0;
    step("beq_not_taken", e_branch(1'b0, ALU_SUB));
    load_instr(OP_BRANCH, 3'b100, 1'b0);
    fetch_decode("blt");
    step("blt_taken", e_branch(1'b1, ALU_SLT));
    load_instr(OP_BRANCH, 3'b111, 1'b0);
    fetch_decode("bgeu");
    step("bgeu_not_taken", e_branch(1'b0, ALU_SLTU));

    // jumps and lui
    load_instr(OP_JAL, 3'b000, 1'b0);
    fetch_decode("jal");
    step("jal_jump", E_JAL);
    step("jal_link", E_ALUWB);
    load_instr(OP_JALR, 3'b000, 1'b0);
    fetch_decode("jalr");
    step("jalr_jump", E_JALR);
    step("jalr_link", E_LINK);
    load_instr(OP_LUI, 3'b000, 1'b0);
    fetch_decode("lui");
    step("lui_exec", ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, ALU_LUI));
    step("lui_aluwb", E_ALUWB);

    // reset while a store is waiting on memory
    load_instr(OP_STORE, 3'b010, 1'b0);
    fetch_decode("sw");
    step("sw_memadr", E_MEMADR);
    mem_ready = 1'b0;
    step("sw_wait", E_MEMWRITE);
    reset = 1'b1;
    step("sw_reset_drop", E_IDLE);
    step("sw_reset_hold", E_IDLE);
    reset = 1'b0;
    step("sw_reset_fetch", e_fetch(1'b0));
    mem_ready = 1'b1;

    // illegal opcode
    load_instr(7'b0000000, 3'b000, 1'b0);
    fetch_decode("illegal");
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    @(negedge clk);
    check("trap_flag", {15'd0, illegal_instr}, 16'd1);
    step("trap_quiet0", E_IDLE);
    step("trap_quiet1", E_IDLE);
    check("trap_flag_sticky", {15'd0, illegal_instr}, 16'd1);
    reset = 1'b1;
    step("trap_reset", E_IDLE);
    reset = 1'b0;
    check("trap_flag_cleared", {15'd0, illegal_instr}, 16'd0);
    step("trap_exit_fetch", e_fetch(1'b1));
`else
    step("illegal_nop_fetch", e_fetch(1'b1));
    step("illegal_nop_decode", E_DECODE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
